// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, state codes, mux keys.
// Optional feature macro: CONTROLE_ADDI_EN (adds ST_ADDI_EXEC / ST_ADDI_WB behaviour).
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // FETCH is all-zero so the forced-zero estado during reset reads as FETCH
    localparam logic [3:0] ST_FETCH     = 4'd0;
    localparam logic [3:0] ST_DECODE    = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
    localparam logic [3:0] ST_MEM_READ  = 4'd3;
    localparam logic [3:0] ST_MEM_WB    = 4'd4;
    localparam logic [3:0] ST_MEM_WRITE = 4'd5;
    localparam logic [3:0] ST_EXEC_R    = 4'd6;
    localparam logic [3:0] ST_R_WB      = 4'd7;
    localparam logic [3:0] ST_BRANCH    = 4'd8;
    localparam logic [3:0] ST_JUMP      = 4'd9;
    localparam logic [3:0] ST_ADDI_EXEC = 4'd10;
    localparam logic [3:0] ST_ADDI_WB   = 4'd11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/controle_saidas.sv
// Combinational state -> control-word decoder for the multicycle MIPS control unit.
// Optional feature macro: CONTROLE_ADDI_EN (decodes the ADDI_EXEC / ADDI_WB states).
module controle_saidas
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic [STATE_W-1:0] estado,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = '0;
        case (estado)
            STATE_W'(ST_FETCH): begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.pc_write  = 1'b1;
            end
            STATE_W'(ST_DECODE): begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            STATE_W'(ST_MEM_ADDR): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            STATE_W'(ST_MEM_READ): begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            STATE_W'(ST_MEM_WB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dst    = 1'b0;
            end
            STATE_W'(ST_MEM_WRITE): begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            STATE_W'(ST_EXEC_R): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            STATE_W'(ST_R_WB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            STATE_W'(ST_BRANCH): begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            STATE_W'(ST_JUMP): begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
`ifdef CONTROLE_ADDI_EN
            STATE_W'(ST_ADDI_EXEC): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            STATE_W'(ST_ADDI_WB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Moore FSM control unit for the multicycle MIPS datapath: state register, next-state, opcode latch.
// Optional feature macro: CONTROLE_ADDI_EN (adds addi via ADDI_EXEC -> ADDI_WB).
module controle_multiciclo
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int STATE_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [OP_W-1:0]    opcode,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               illegal_op,
    output logic [STATE_W-1:0] estado
);

    logic [STATE_W-1:0] estado_q;
    logic [STATE_W-1:0] estado_d;
    logic [OP_W-1:0]    op_q;
    logic               op_unknown;
    ctrl_t              ctrl;
    ctrl_t              ctrl_g;

    always_comb begin
        estado_d   = STATE_W'(ST_FETCH);
        op_unknown = 1'b0;
        case (estado_q)
            STATE_W'(ST_FETCH):     estado_d = STATE_W'(ST_DECODE);
            STATE_W'(ST_DECODE): begin
                if (opcode == OP_W'(OP_LW) || opcode == OP_W'(OP_SW))
                    estado_d = STATE_W'(ST_MEM_ADDR);
                else if (opcode == OP_W'(OP_RTYPE))
                    estado_d = STATE_W'(ST_EXEC_R);
                else if (opcode == OP_W'(OP_BEQ))
                    estado_d = STATE_W'(ST_BRANCH);
                else if (opcode == OP_W'(OP_J))
                    estado_d = STATE_W'(ST_JUMP);
`ifdef CONTROLE_ADDI_EN
                else if (opcode == OP_W'(OP_ADDI))
                    estado_d = STATE_W'(ST_ADDI_EXEC);
`endif
                else
                    op_unknown = 1'b1;
            end
            // Decided from the latched opcode so IR changes after DECODE are ignored
            STATE_W'(ST_MEM_ADDR):
                estado_d = (op_q == OP_W'(OP_LW)) ? STATE_W'(ST_MEM_READ) : STATE_W'(ST_MEM_WRITE);
            STATE_W'(ST_MEM_READ):  estado_d = STATE_W'(ST_MEM_WB);
            STATE_W'(ST_MEM_WB):    estado_d = STATE_W'(ST_FETCH);
            STATE_W'(ST_MEM_WRITE): estado_d = STATE_W'(ST_FETCH);
            STATE_W'(ST_EXEC_R):    estado_d = STATE_W'(ST_R_WB);
            STATE_W'(ST_R_WB):      estado_d = STATE_W'(ST_FETCH);
            STATE_W'(ST_BRANCH):    estado_d = STATE_W'(ST_FETCH);
            STATE_W'(ST_JUMP):      estado_d = STATE_W'(ST_FETCH);
`ifdef CONTROLE_ADDI_EN
            STATE_W'(ST_ADDI_EXEC): estado_d = STATE_W'(ST_ADDI_WB);
            STATE_W'(ST_ADDI_WB):   estado_d = STATE_W'(ST_FETCH);
`endif
            default:                estado_d = STATE_W'(ST_FETCH);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= STATE_W'(ST_FETCH);
            op_q     <= '0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == STATE_W'(ST_DECODE))
                op_q <= opcode;
        end
    end

    controle_saidas #(
        .STATE_W (STATE_W)
    ) u_saidas (
        .estado (estado_q),
        .ctrl   (ctrl)
    );

    // Reset masks every output combinationally so no strobe escapes in the reset cycle
    assign ctrl_g        = reset ? '0 : ctrl;
    assign pc_write      = ctrl_g.pc_write;
    assign pc_write_cond = ctrl_g.pc_write_cond;
    assign i_or_d        = ctrl_g.i_or_d;
    assign mem_read      = ctrl_g.mem_read;
    assign mem_write     = ctrl_g.mem_write;
    assign ir_write      = ctrl_g.ir_write;
    assign mem_to_reg    = ctrl_g.mem_to_reg;
    assign reg_dst       = ctrl_g.reg_dst;
    assign reg_write     = ctrl_g.reg_write;
    assign alu_src_a     = ctrl_g.alu_src_a;
    assign alu_src_b     = ctrl_g.alu_src_b;
    assign alu_op        = ctrl_g.alu_op;
    assign pc_source     = ctrl_g.pc_source;
    assign illegal_op    = ~reset & op_unknown;
    assign estado        = reset ? '0 : estado_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: vector table, reset sequences, random instruction stream.
// Honours CONTROLE_ADDI_EN the same way as the design.
module tb_controle_multiciclo;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } cw_t;

    typedef struct {
        logic [5:0]  op;
        int unsigned lat;
        int unsigned step;
        cw_t         exp;
        logic [3:0]  st;
        string       name;
    } vec_t;

    localparam cw_t W_ZERO      = '0;
    localparam cw_t W_FETCH     = '{mem_read: 1'b1, ir_write: 1'b1, pc_write: 1'b1, alu_src_b: 2'd1, default: '0};
    localparam cw_t W_DECODE    = '{alu_src_b: 2'd3, default: '0};
    localparam cw_t W_DEC_ILL   = '{alu_src_b: 2'd3, illegal_op: 1'b1, default: '0};
    localparam cw_t W_MEM_ADDR  = '{alu_src_a: 1'b1, alu_src_b: 2'd2, default: '0};
    localparam cw_t W_MEM_READ  = '{mem_read: 1'b1, i_or_d: 1'b1, default: '0};
    localparam cw_t W_MEM_WB    = '{reg_write: 1'b1, mem_to_reg: 1'b1, default: '0};
    localparam cw_t W_MEM_WRITE = '{mem_write: 1'b1, i_or_d: 1'b1, default: '0};
    localparam cw_t W_EXEC_R    = '{alu_src_a: 1'b1, alu_op: 2'd2, default: '0};
    localparam cw_t W_R_WB      = '{reg_write: 1'b1, reg_dst: 1'b1, default: '0};
    localparam cw_t W_BRANCH    = '{alu_src_a: 1'b1, alu_op: 2'd1, pc_write_cond: 1'b1, pc_source: 2'd1, default: '0};
    localparam cw_t W_JUMP      = '{pc_write: 1'b1, pc_source: 2'd2, default: '0};
    localparam cw_t W_ADDI_WB   = '{reg_write: 1'b1, default: '0};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] estado;

    int unsigned checks = 0;
    int unsigned errors = 0;
    cw_t         exp_q[$];
    vec_t        tbl[$];

    always #5 clock = ~clock;

    controle_multiciclo #(
        .OP_W    (6),
        .STATE_W (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .estado        (estado)
    );

    function automatic cw_t actual();
        cw_t a;
        a = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
              reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};
        return a;
    endfunction

    task automatic check_word(input string name, input cw_t exp);
        cw_t a;
        a = actual();
        checks++;
        if (a !== exp) begin
            errors++;
            $display("FAIL %s: got control word %h, expected %h", name, a, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [3:0] exp);
        checks++;
        if (estado !== exp) begin
            errors++;
            $display("FAIL %s: got estado %0d, expected %0d", name, estado, exp);
        end
    endtask

    // Reference: expected control word for each cycle from FETCH up to the next FETCH
    task automatic build_expected(input logic [5:0] op);
        exp_q.delete();
        exp_q.push_back(W_FETCH);
        case (op)
            6'b100011: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_MEM_ADDR);
                exp_q.push_back(W_MEM_READ);
                exp_q.push_back(W_MEM_WB);
            end
            6'b101011: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_MEM_ADDR);
                exp_q.push_back(W_MEM_WRITE);
            end
            6'b000000: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_EXEC_R);
                exp_q.push_back(W_R_WB);
            end
            6'b000100: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_BRANCH);
            end
            6'b000010: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_JUMP);
            end
`ifdef CONTROLE_ADDI_EN
            6'b001000: begin
                exp_q.push_back(W_DECODE);
                exp_q.push_back(W_MEM_ADDR);
                exp_q.push_back(W_ADDI_WB);
            end
`endif
            default: exp_q.push_back(W_DEC_ILL);
        endcase
    endtask

    // Opcode is only meaningful in DECODE; scramble it on every other cycle
    task automatic run_seq(input logic [5:0] op, input string name);
        build_expected(op);
        for (int unsigned i = 0; i < exp_q.size(); i++) begin
            @(negedge clock);
            opcode = (i == 1) ? op : 6'($urandom);
            #1;
            check_word(name, exp_q[i]);
            if (i == 0) check_state({name, "_fetch_state"}, ST_FETCH);
        end
    endtask

    initial begin
        tbl.push_back('{op: 6'b100011, lat: 5, step: 0, exp: W_FETCH,     st: ST_FETCH,     name: "fetch_word"});
        tbl.push_back('{op: 6'b100011, lat: 5, step: 3, exp: W_MEM_READ,  st: ST_MEM_READ,  name: "lw_mem_read"});
        tbl.push_back('{op: 6'b100011, lat: 5, step: 4, exp: W_MEM_WB,    st: ST_MEM_WB,    name: "lw_mem_wb"});
        tbl.push_back('{op: 6'b101011, lat: 4, step: 2, exp: W_MEM_ADDR,  st: ST_MEM_ADDR,  name: "sw_mem_addr"});
        tbl.push_back('{op: 6'b101011, lat: 4, step: 3, exp: W_MEM_WRITE, st: ST_MEM_WRITE, name: "sw_mem_write"});
        tbl.push_back('{op: 6'b000000, lat: 4, step: 2, exp: W_EXEC_R,    st: ST_EXEC_R,    name: "r_exec"});
        tbl.push_back('{op: 6'b000000, lat: 4, step: 3, exp: W_R_WB,      st: ST_R_WB,      name: "r_wb"});
        tbl.push_back('{op: 6'b000100, lat: 3, step: 2, exp: W_BRANCH,    st: ST_BRANCH,    name: "beq_branch"});
        tbl.push_back('{op: 6'b000010, lat: 3, step: 2, exp: W_JUMP,      st: ST_JUMP,      name: "j_jump"});
        tbl.push_back('{op: 6'b111111, lat: 2, step: 1, exp: W_DEC_ILL,   st: ST_DECODE,    name: "illegal_decode"});
        tbl.push_back('{op: 6'b000010, lat: 3, step: 1, exp: W_DECODE,    st: ST_DECODE,    name: "decode_word"});
`ifdef CONTROLE_ADDI_EN
        tbl.push_back('{op: 6'b001000, lat: 4, step: 3, exp: W_ADDI_WB,   st: ST_ADDI_WB,   name: "addi_wb"});
`else
        tbl.push_back('{op: 6'b001000, lat: 2, step: 1, exp: W_DEC_ILL,   st: ST_DECODE,    name: "addi_illegal"});
`endif

        // Power-on reset held for two cycles
        reset  = 1'b1;
        opcode = 6'b111111;
        for (int unsigned i = 0; i < 2; i++) begin
            @(negedge clock);
            #1;
            check_word("por_outputs_zero", W_ZERO);
            check_state("por_estado", 4'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_word("por_release_fetch", W_FETCH);
        check_state("por_release_state", ST_FETCH);
        @(negedge clock);
        opcode = 6'b111111;
        #1;
        check_word("post_reset_illegal", W_DEC_ILL);

        // Table vectors; the FETCH-state check at step 0 also confirms the previous latency
        foreach (tbl[k]) begin
            for (int unsigned s = 0; s < tbl[k].lat; s++) begin
                @(negedge clock);
                opcode = (s == 1) ? tbl[k].op : 6'($urandom);
                #1;
                if (s == 0) check_state({tbl[k].name, "_start"}, ST_FETCH);
                if (s == tbl[k].step) begin
                    check_word(tbl[k].name, tbl[k].exp);
                    check_state({tbl[k].name, "_state"}, tbl[k].st);
                end
            end
        end

        // Reset for two cycles in the middle of an R-type instruction
        @(negedge clock);
        opcode = 6'($urandom);
        #1;
        check_word("rst_mid_fetch", W_FETCH);
        @(negedge clock);
        opcode = 6'b000000;
        #1;
        check_word("rst_mid_decode", W_DECODE);
        @(negedge clock);
        opcode = 6'b111111;
        #1;
        check_word("rst_mid_exec", W_EXEC_R);
        reset = 1'b1;
        #1;
        check_word("rst_mid_zero1", W_ZERO);
        @(negedge clock);
        #1;
        check_word("rst_mid_zero2", W_ZERO);
        check_state("rst_mid_estado", 4'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_word("rst_mid_release_fetch", W_FETCH);
        check_state("rst_mid_release_state", ST_FETCH);
        @(negedge clock);
        opcode = 6'b000100;
        #1;
        check_word("rst_mid_then_decode", W_DECODE);
        @(negedge clock);
        opcode = 6'($urandom);
        #1;
        check_word("rst_mid_then_branch", W_BRANCH);

        // Random instruction stream against the reference model
        for (int unsigned n = 0; n < 300; n++) begin
            logic [5:0] op;
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            run_seq(op, "random_instr");
        end

        @(negedge clock);
        #1;
        check_state("final_fetch", ST_FETCH);
        check_word("final_fetch_word", W_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
